// File: rtl/wb_vga_pkg.sv
// Shared constants for the Wishbone-programmable VGA timing generator:
// register map, CTRL/STATUS bit positions and default 640x480@60 timing.
package wb_vga_pkg;

    localparam int unsigned WB_AW     = 32;
    localparam int unsigned WB_DW     = 32;
    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned CTRL_W    = 4;
    localparam int unsigned FRAME_W   = 16;

    localparam logic [REG_IDX_W-1:0] REG_CTRL   = 4'd0;
    localparam logic [REG_IDX_W-1:0] REG_STATUS = 4'd1;
    localparam logic [REG_IDX_W-1:0] REG_H_ACT  = 4'd2;
    localparam logic [REG_IDX_W-1:0] REG_V_BP   = 4'd9;

    // Position of each timing field inside the programmed/shadow register sets
    localparam int unsigned TIM_NUM   = 8;
    localparam int unsigned TIM_H_ACT = 0;
    localparam int unsigned TIM_H_FP  = 1;
    localparam int unsigned TIM_H_SYN = 2;
    localparam int unsigned TIM_H_BP  = 3;
    localparam int unsigned TIM_V_ACT = 4;
    localparam int unsigned TIM_V_FP  = 5;
    localparam int unsigned TIM_V_SYN = 6;
    localparam int unsigned TIM_V_BP  = 7;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_HPOL   = 1;
    localparam int unsigned CTRL_VPOL   = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;

    localparam int unsigned ST_IN_VBLANK = 16;
    localparam int unsigned ST_IRQ_PEND  = 17;

    localparam int unsigned DEF_H_ACT  = 640;
    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;
    localparam int unsigned DEF_V_ACT  = 480;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;

endpackage

// File: rtl/wb_vga_timing_gen_if.sv
// Wishbone classic slave bus used to program the VGA timing generator.
interface wb_vga_timing_gen_if;
    import wb_vga_pkg::*;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic             ack;
    logic [WB_DW-1:0] dout;

    modport master (output cyc, stb, we, adr, dat, input ack, dout);
    modport slave  (input cyc, stb, we, adr, dat, output ack, dout);

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running position counter plus active/sync/wrap decode
// derived from the four timing fields of that axis.
module vga_axis_counter #(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             advance,
    input  logic [CNT_W-1:0] act,
    input  logic [CNT_W-1:0] fp,
    input  logic [CNT_W-1:0] sync,
    input  logic [CNT_W-1:0] bp,
    output logic [CNT_W-1:0] cnt,
    output logic             active_c,
    output logic             sync_act_c,
    output logic             wrap_c
);
    localparam int unsigned SW = CNT_W + 1;

    logic [SW-1:0] sync_lo;
    logic [SW-1:0] sync_hi;
    logic [SW-1:0] total;
    logic [SW-1:0] cnt_x;

    // Boundaries computed one bit wider so the sums never wrap for legal timing
    assign sync_lo    = SW'(act) + SW'(fp);
    assign sync_hi    = sync_lo + SW'(sync);
    assign total      = sync_hi + SW'(bp);
    assign cnt_x      = SW'(cnt);
    assign active_c   = cnt_x < SW'(act);
    assign sync_act_c = (cnt_x >= sync_lo) && (cnt_x < sync_hi);
    assign wrap_c     = advance && (cnt_x == (total - SW'(1)));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_vga_timing_gen.sv
// Programmable VGA raster timing generator with Wishbone register access,
// frame-boundary shadowing of timing, a frame counter and a vblank interrupt.
module wb_vga_timing_gen
    import wb_vga_pkg::*;
#(
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned H_ACT_RST  = DEF_H_ACT,
    parameter int unsigned H_FP_RST   = DEF_H_FP,
    parameter int unsigned H_SYNC_RST = DEF_H_SYNC,
    parameter int unsigned H_BP_RST   = DEF_H_BP,
    parameter int unsigned V_ACT_RST  = DEF_V_ACT,
    parameter int unsigned V_FP_RST   = DEF_V_FP,
    parameter int unsigned V_SYNC_RST = DEF_V_SYNC,
    parameter int unsigned V_BP_RST   = DEF_V_BP
) (
    input  logic               clk,
    input  logic               rst,
    wb_vga_timing_gen_if.slave wb,
    output logic               n_blank,
    output logic               n_sync,
    output logic               h_sync,
    output logic               v_sync,
    output logic               display_enable,
    output logic [CNT_W-1:0]   row,
    output logic [CNT_W-1:0]   column,
    output logic               irq
);
    localparam int unsigned SW        = CNT_W + 1;
    localparam int unsigned TIM_IDX_W = 3;

    localparam logic [CNT_W-1:0] TIM_RST [TIM_NUM] = '{
        CNT_W'(H_ACT_RST), CNT_W'(H_FP_RST), CNT_W'(H_SYNC_RST), CNT_W'(H_BP_RST),
        CNT_W'(V_ACT_RST), CNT_W'(V_FP_RST), CNT_W'(V_SYNC_RST), CNT_W'(V_BP_RST)
    };

    logic [CTRL_W-1:0]    ctrl;
    logic [CNT_W-1:0]     prog   [TIM_NUM];
    logic [CNT_W-1:0]     shadow [TIM_NUM];
    logic [FRAME_W-1:0]   frame_cnt;
    logic                 irq_pend;

    logic                 en;
    logic [REG_IDX_W-1:0] reg_idx;
    logic [TIM_IDX_W-1:0] tim_idx;
    logic                 is_tim;
    logic                 req;
    logic                 wr;
    logic [WB_DW-1:0]     rdata;
    logic                 unused_bits;

    logic [CNT_W-1:0]     h_cnt;
    logic [CNT_W-1:0]     v_cnt;
    logic                 h_active, h_sync_act, h_wrap;
    logic                 v_active, v_sync_act, v_wrap;
    logic                 visible;
    logic                 vblank_ev;
    logic                 in_vblank;

    assign en          = ctrl[CTRL_EN];
    assign reg_idx     = wb.adr[5:2];
    assign is_tim      = (reg_idx >= REG_H_ACT) && (reg_idx <= REG_V_BP);
    assign tim_idx     = TIM_IDX_W'(reg_idx - REG_H_ACT);
    assign req         = wb.cyc && wb.stb && !wb.ack;
    assign wr          = req && wb.we;
    assign unused_bits = &{1'b0, wb.adr[WB_AW-1:6], wb.adr[1:0], wb.dat};

    vga_axis_counter #(.CNT_W(CNT_W)) u_h_axis (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .advance    (en),
        .act        (shadow[TIM_H_ACT]),
        .fp         (shadow[TIM_H_FP]),
        .sync       (shadow[TIM_H_SYN]),
        .bp         (shadow[TIM_H_BP]),
        .cnt        (h_cnt),
        .active_c   (h_active),
        .sync_act_c (h_sync_act),
        .wrap_c     (h_wrap)
    );

    vga_axis_counter #(.CNT_W(CNT_W)) u_v_axis (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .advance    (h_wrap),
        .act        (shadow[TIM_V_ACT]),
        .fp         (shadow[TIM_V_FP]),
        .sync       (shadow[TIM_V_SYN]),
        .bp         (shadow[TIM_V_BP]),
        .cnt        (v_cnt),
        .active_c   (v_active),
        .sync_act_c (v_sync_act),
        .wrap_c     (v_wrap)
    );

    assign visible   = h_active && v_active;
    assign in_vblank = !v_active;
    // Fires on the edge that moves the raster to (h=0, v=V_ACT)
    assign vblank_ev = h_wrap && !v_wrap &&
                       ((SW'(v_cnt) + SW'(1)) == SW'(shadow[TIM_V_ACT]));

    // Register read mux
    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL: rdata = WB_DW'(ctrl);
            REG_STATUS: begin
                rdata[FRAME_W-1:0]  = frame_cnt;
                rdata[ST_IN_VBLANK] = in_vblank;
                rdata[ST_IRQ_PEND]  = irq_pend;
            end
            default: begin
                if (is_tim) rdata = WB_DW'(prog[tim_idx]);
            end
        endcase
    end

    // Wishbone slave and programmed registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wb.ack  <= 1'b0;
            wb.dout <= '0;
            ctrl    <= '0;
            prog    <= TIM_RST;
        end else begin
            wb.ack  <= req;
            wb.dout <= (req && !wb.we) ? rdata : '0;
            if (wr) begin
                if (reg_idx == REG_CTRL) begin
                    ctrl <= wb.dat[CTRL_W-1:0];
                end else if (is_tim) begin
                    prog[tim_idx] <= (wb.dat[CNT_W-1:0] == '0) ? CNT_W'(1) : wb.dat[CNT_W-1:0];
                end
            end
        end
    end

    // Active timing follows the programmed set only at frame wrap or while stopped
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= TIM_RST;
        end else if (!en || v_wrap) begin
            shadow <= prog;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            irq_pend  <= 1'b0;
        end else if (vblank_ev) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
            irq_pend  <= 1'b1;
        end else if (wr && (reg_idx == REG_STATUS) && wb.dat[ST_IRQ_PEND]) begin
            irq_pend  <= 1'b0;
        end
    end

    // Registered video outputs, one cycle behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            n_blank        <= 1'b0;
            display_enable <= 1'b0;
            row            <= '0;
            column         <= '0;
            n_sync         <= 1'b1;
            h_sync         <= 1'b1;
            v_sync         <= 1'b1;
            irq            <= 1'b0;
        end else begin
            irq <= irq_pend && ctrl[CTRL_IRQ_EN];
            if (!en) begin
                n_blank        <= 1'b0;
                display_enable <= 1'b0;
                row            <= '0;
                column         <= '0;
                n_sync         <= 1'b1;
                h_sync         <= !ctrl[CTRL_HPOL];
                v_sync         <= !ctrl[CTRL_VPOL];
            end else begin
                n_blank        <= visible;
                display_enable <= visible;
                row            <= visible ? v_cnt : '0;
                column         <= visible ? h_cnt : '0;
                n_sync         <= !(h_sync_act || v_sync_act);
                h_sync         <= h_sync_act ~^ ctrl[CTRL_HPOL];
                v_sync         <= v_sync_act ~^ ctrl[CTRL_VPOL];
            end
        end
    end

endmodule

// File: tb/tb_wb_vga_timing_gen.sv
// Scoreboard bench: a frame-position reference model predicts every cycle's
// outputs and every read response; monitors compare them against the DUT.
module tb_wb_vga_timing_gen;

    typedef struct packed {
        logic        ack;
        logic        n_blank;
        logic        n_sync;
        logic        h_sync;
        logic        v_sync;
        logic        de;
        logic [11:0] row;
        logic [11:0] col;
        logic        irq;
    } vid_t;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] d;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        n_blank, n_sync, h_sync, v_sync, display_enable, irq;
    logic [11:0] row, column;

    int checks = 0;
    int errors = 0;

    vid_t vid_q[$];
    rd_t  rd_q[$];

    wb_vga_timing_gen_if wbif ();

    wb_vga_timing_gen dut (
        .clk            (clk),
        .rst            (rst),
        .wb             (wbif),
        .n_blank        (n_blank),
        .n_sync         (n_sync),
        .h_sync         (h_sync),
        .v_sync         (v_sync),
        .display_enable (display_enable),
        .row            (row),
        .column         (column),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    // Reference model: raster position is a cycle index within the frame
    int DEF_TIM [8] = '{640, 16, 96, 48, 480, 10, 2, 33};
    int m_prog [8];
    int m_act  [8];
    int m_ctrl, m_pos, m_frames;
    bit m_pend, m_ack;

    always @(posedge clk) begin
        vid_t        e;
        rd_t         r;
        int          ht, vt, h, v, idx;
        bit          en, hpol, vpol, vis, hs, vs, req, ev;
        logic [31:0] wdat;
        e = '0;
        if (rst) begin
            e.n_sync = 1'b1; e.h_sync = 1'b1; e.v_sync = 1'b1;
            m_ctrl = 0; m_prog = DEF_TIM; m_act = DEF_TIM;
            m_pos = 0; m_frames = 0; m_pend = 0; m_ack = 0;
        end else begin
            en   = m_ctrl[0];
            hpol = m_ctrl[1];
            vpol = m_ctrl[2];
            ht = m_act[0] + m_act[1] + m_act[2] + m_act[3];
            vt = m_act[4] + m_act[5] + m_act[6] + m_act[7];
            h  = m_pos % ht;
            v  = m_pos / ht;
            e.irq = m_pend && m_ctrl[3];
            if (!en) begin
                e.n_sync = 1'b1;
                e.h_sync = !hpol;
                e.v_sync = !vpol;
            end else begin
                vis = (h < m_act[0]) && (v < m_act[4]);
                hs  = (h >= m_act[0] + m_act[1]) && (h < m_act[0] + m_act[1] + m_act[2]);
                vs  = (v >= m_act[4] + m_act[5]) && (v < m_act[4] + m_act[5] + m_act[6]);
                e.n_blank = vis;
                e.de      = vis;
                e.row     = vis ? 12'(v) : 12'd0;
                e.col     = vis ? 12'(h) : 12'd0;
                e.n_sync  = !(hs || vs);
                e.h_sync  = hs ? hpol : !hpol;
                e.v_sync  = vs ? vpol : !vpol;
            end
            req  = wbif.cyc && wbif.stb && !m_ack;
            idx  = int'(wbif.adr[5:2]);
            wdat = wbif.dat;
            if (req) begin
                r.is_rd = !wbif.we;
                r.d     = '0;
                if (idx == 0) r.d = 32'(m_ctrl);
                else if (idx == 1) r.d = {14'd0, m_pend, (v >= m_act[4]), 16'(m_frames)};
                else if (idx <= 9) r.d = 32'(m_prog[idx-2]);
                rd_q.push_back(r);
            end
            ev = 0;
            if (en) begin
                m_pos++;
                if (m_pos == ht * vt) begin
                    m_pos = 0;
                    m_act = m_prog;
                end else if (m_pos == m_act[4] * ht) begin
                    ev = 1;
                end
            end else begin
                m_pos = 0;
                m_act = m_prog;
            end
            if (req && wbif.we) begin
                if (idx == 0) m_ctrl = int'(wdat[3:0]);
                else if (idx == 1 && wdat[17]) m_pend = 0;
                else if (idx >= 2 && idx <= 9) m_prog[idx-2] = (wdat[11:0] == 0) ? 1 : int'(wdat[11:0]);
            end
            if (ev) begin
                m_frames = (m_frames + 1) % 65536;
                m_pend   = 1;
            end
            m_ack = req;
            e.ack = req;
        end
        vid_q.push_back(e);
    end

    // Monitor: compare every cycle's outputs and each acked read's data
    always @(negedge clk) begin
        vid_t got, e;
        rd_t  r;
        got = {wbif.ack, n_blank, n_sync, h_sync, v_sync, display_enable, row, column, irq};
        checks++;
        if (vid_q.size() == 0) begin
            errors++;
            $display("FAIL outputs t=%0t no expectation queued, got=%h", $time, got);
        end else begin
            e = vid_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got=%h expected=%h", $time, got, e);
            end
        end
        if (wbif.ack === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack t=%0t ack without a queued access", $time);
            end else begin
                r = rd_q.pop_front();
                if (r.is_rd) begin
                    checks++;
                    if (wbif.dout !== r.d) begin
                        errors++;
                        $display("FAIL rdata t=%0t got=%h expected=%h", $time, wbif.dout, r.d);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wb_access(input bit w, input int idx, input logic [31:0] d);
        bit seen;
        @(negedge clk);
        wbif.cyc = 1'b1; wbif.stb = 1'b1; wbif.we = w;
        wbif.adr = {26'd0, 4'(idx), 2'd0};
        wbif.dat = d;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = (wbif.ack === 1'b1);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout idx=%0d got no ack required ack", idx);
        end
        wbif.cyc = 1'b0; wbif.stb = 1'b0; wbif.we = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) wb_access(1'b0, i, 32'd0);
    endtask

    task automatic wait_irq();
        int n = 0;
        while (irq !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (irq !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL irq_rise got irq=%b required 1 within 300 cycles", irq);
        end
    endtask

    initial begin
        int k;
        wbif.cyc = 1'b0; wbif.stb = 1'b0; wbif.we = 1'b0;
        wbif.adr = '0;   wbif.dat = '0;
        idle(3);
        rst = 1'b0;

        read_all();

        // Small raster: H=4/1/2/1, V=3/1/1/1
        wb_access(1'b1, 2, 4); wb_access(1'b1, 3, 1); wb_access(1'b1, 4, 2); wb_access(1'b1, 5, 1);
        wb_access(1'b1, 6, 3); wb_access(1'b1, 7, 1); wb_access(1'b1, 8, 1); wb_access(1'b1, 9, 1);
        wb_access(1'b1, 0, 32'h7);
        idle(110);
        wb_access(1'b0, 1, 0);

        wb_access(1'b1, 0, 32'hF);
        wait_irq();
        wb_access(1'b0, 1, 0);
        wb_access(1'b1, 1, 32'h0002_0000);
        wb_access(1'b0, 1, 0);
        idle(48);
        wb_access(1'b0, 1, 0);

        idle(13);
        wb_access(1'b1, 2, 6);
        idle(130);

        wb_access(1'b1, 4, 0);
        wb_access(1'b0, 4, 0);
        idle(7);
        wb_access(1'b1, 0, 32'h6);
        idle(5);
        wb_access(1'b1, 0, 32'h1);
        idle(23);

        // Reset lands mid-frame and on the request cycle of a write
        @(negedge clk);
        wbif.cyc = 1'b1; wbif.stb = 1'b1; wbif.we = 1'b1;
        wbif.adr = {26'd0, 4'd2, 2'd0}; wbif.dat = 32'd7;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wbif.cyc = 1'b0; wbif.stb = 1'b0; wbif.we = 1'b0;
        read_all();

        for (int it = 0; it < 6; it++) begin
            wb_access(1'b1, 0, 32'h0);
            for (int i = 2; i < 10; i++) wb_access(1'b1, i, 32'($urandom_range(0, 4)));
            wb_access(1'b1, 0, {28'd0, 3'($urandom_range(0, 7)), 1'b1});
            for (int s = 0; s < 40; s++) begin
                k = $urandom_range(0, 9);
                if (k < 3) idle($urandom_range(1, 30));
                else if (k < 6) wb_access(1'b0, $urandom_range(0, 15), 32'd0);
                else if (k < 8) wb_access(1'b1, $urandom_range(2, 9), 32'($urandom_range(0, 5)));
                else if (k == 8) wb_access(1'b1, 1, {14'd0, 1'($urandom_range(0, 1)), 17'd0});
                else wb_access(1'b1, 0, {28'd0, 3'($urandom_range(0, 7)),
                                         1'($urandom_range(0, 9) != 0)});
            end
        end

        idle(3);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
